// File: rtl/v4_pulse_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// package_settings_v_4
//   Shared settings for the v4 pulse controller: sample width, FSM state
//   encoding, the result record pushed into the result FIFO, and the default
//   timing / depth constants used as parameter defaults by v4_pulse_ctrl.
//   The result record carries a timestamp field only when
//   V4_PULSE_CTRL_TIMESTAMP_EN is defined.
// ---------------------------------------------------------------------------
package package_settings_v_4;

  localparam int SIZE_FILTER_DATA = 16;

  localparam int V4_PC_SETTLE     = 8;
  localparam int V4_PC_HOLDOFF    = 16;
  localparam int V4_PC_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ARMED   = 3'd2,
    PEAK    = 3'd3,
    HOLDOFF = 3'd4
  } v4_pc_state_t;

  // "time" is a reserved word, so the timestamp field is called tstamp.
  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amp;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
    logic [31:0]                        tstamp;
`endif
  } v4_pc_result_t;

endpackage

// File: rtl/v4_pc_fifo.sv
// ---------------------------------------------------------------------------
// v4_pc_fifo
//   Synchronous FIFO holding captured results. DEPTH must be a power of two
//   so the pointers wrap naturally. A write to a full FIFO is accepted only
//   when a read happens in the same cycle. rd_data shows the head entry and
//   reads as zero while empty.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, wr_data  write request and data
//   rd_en           read (pop) request, ignored while empty
//   rd_data         head entry
//   full, empty     occupancy flags
//   count           number of stored entries
// ---------------------------------------------------------------------------
module v4_pc_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [15:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  T                       wr_data,
  input  logic                   rd_en,
  output T                       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_wr;
  logic           do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Gating on empty keeps the output at zero after reset without having to
  // clear the storage array.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem[rd_ptr];
  end

endmodule

// File: rtl/v4_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// v4_pulse_ctrl
//   Peak-capture controller for a filter output stream. After enable it lets
//   the filter settle, arms on a threshold crossing, tracks the peak, queues
//   the peak amplitude into a result FIFO and then waits a holdoff period
//   before re-arming.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | filter held cleared, waiting for enable
//   SETTLE  | filter running, crossings ignored for SETTLE_CYCLES
//   ARMED   | waiting for filt_data > threshold
//   PEAK    | tracking the maximum until the signal falls
//   HOLDOFF | dead time after a capture, crossings ignored
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   enable              run request; dropping it returns to IDLE
//   threshold           signed trigger level
//   filt_data           signed filter sample, one per clk
//   filt_run            filter run/clear control (0 = cleared)
//   busy                state is not IDLE
//   res_valid/res_ready result handshake
//   res_amp             head result amplitude
//   res_time            head result timestamp (macro builds only)
//   ov f_cnt            dropped-result counter, saturating at 255
//
// Build option: V4_PULSE_CTRL_TIMESTAMP_EN adds a free-running 32-bit
// timestamp captured with every peak update and output on res_time.
// ---------------------------------------------------------------------------
module v4_pulse_ctrl
  import package_settings_v_4::*;
#(
  parameter int SETTLE_CYCLES  = V4_PC_SETTLE,
  parameter int HOLDOFF_CYCLES = V4_PC_HOLDOFF,
  parameter int FIFO_DEPTH     = V4_PC_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
  output logic                               filt_run,
  output logic                               busy,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] res_amp,
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
  output logic [31:0]                        res_time,
`endif
  output logic [7:0]                         ovf_cnt
);

  v4_pc_state_t                       state;
  logic [15:0]                        cnt;
  logic signed [SIZE_FILTER_DATA-1:0] peak_max;
  logic                               push;
  logic                               pop;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]        fifo_count;
  logic                               unused_fifo_count;
  v4_pc_result_t                      push_data;
  v4_pc_result_t                      head;

`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] peak_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // The falling sample in PEAK pushes on the same edge that enters HOLDOFF,
  // so res_valid rises in the first HOLDOFF cycle. A disable wins and drops
  // the in-progress peak.
  always_comb begin
    push = (state == PEAK) && enable && (filt_data < peak_max);
    pop  = res_valid && res_ready;
  end

  always_comb begin
    push_data     = '0;
    push_data.amp = peak_max;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
    push_data.tstamp = peak_ts;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      peak_max <= '0;
      filt_run <= 1'b0;
      busy     <= 1'b0;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
      peak_ts  <= '0;
`endif
    end else if (state != IDLE && !enable) begin
      state    <= IDLE;
      filt_run <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= SETTLE;
            cnt      <= 16'(SETTLE_CYCLES - 1);
            filt_run <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SETTLE, HOLDOFF: begin
          if (cnt == '0) state <= ARMED;
          else           cnt   <= cnt - 16'd1;
        end
        ARMED: begin
          if (filt_data > threshold) begin
            state    <= PEAK;
            peak_max <= filt_data;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
            peak_ts  <= ts_cnt;
`endif
          end
        end
        PEAK: begin
          if (filt_data > peak_max) begin
            peak_max <= filt_data;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
            peak_ts  <= ts_cnt;
`endif
          end else if (filt_data < peak_max) begin
            state <= HOLDOFF;
            cnt   <= 16'(HOLDOFF_CYCLES - 1);
          end
        end
        default: begin
          state    <= IDLE;
          filt_run <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so only push-without-pop on a full
  // FIFO counts as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (push && fifo_full && !pop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  v4_pc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (v4_pc_result_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy count is not needed by the controller itself.
  assign unused_fifo_count = ^fifo_count;

  assign res_valid = ~fifo_empty;
  assign res_amp   = head.amp;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
  assign res_time  = head.tstamp;
`endif

endmodule

// File: tb/tb_v4_pulse_ctrl.sv
module tb_v4_pulse_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] threshold;
  logic signed [15:0] filt_data;
  logic               filt_run;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_amp;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
  logic [31:0]        res_time;
`endif
  logic [7:0]         ovf_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  v4_pulse_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .threshold (threshold),
    .filt_data (filt_data),
    .filt_run  (filt_run),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_amp   (res_amp),
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
    .res_time  (res_time),
`endif
    .ovf_cnt   (ovf_cnt)
  );

  typedef struct {
    logic        en;
    logic [15:0] fd;
    logic        rdy;
    logic        e_run;
    logic        e_busy;
    logic        e_valid;
    logic [15:0] e_amp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [15:0] fd, input logic rdy,
                     input logic e_run, input logic e_busy, input logic e_valid,
                     input logic [15:0] e_amp);
    vec_t v;
    v.en = en; v.fd = fd; v.rdy = rdy;
    v.e_run = e_run; v.e_busy = e_busy; v.e_valid = e_valid; v.e_amp = e_amp;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next
  // falling edge, half a period after the rising edge that consumed them.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_fd(input logic [15:0] fd);
    filt_data = fd;
    tick();
  endtask

  // From IDLE: one edge to enter SETTLE, eight SETTLE cycles, then ARMED.
  task automatic start_run();
    enable    = 1'b1;
    filt_data = 16'sd0;
    repeat (9) tick();
  endtask

  task automatic pulse(input logic [15:0] amp, input int gap);
    tick_fd(amp);
    tick_fd(16'd0);
    repeat (gap) tick();
  endtask

  // Pops with res_ready=1 and compares each head entry in order.
  task automatic drain(input string nm, input int exp_n, input logic [63:0] exp_amps);
    int n = 0;
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
    logic [31:0] last_ts = '0;
`endif
    res_ready = 1'b1;
    filt_data = 16'sd0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid) begin
        if (n < 4)
          check($sformatf("%s amp%0d", nm, n), 32'(res_amp), 32'(exp_amps[63-16*n -: 16]));
`ifdef V4_PULSE_CTRL_TIMESTAMP_EN
        if (n > 0) check($sformatf("%s ts_incr%0d", nm, n), 32'(res_time > last_ts), 32'd1);
        last_ts = res_time;
`endif
        n++;
      end
      tick();
    end
    res_ready = 1'b0;
    check({nm, " pops"}, 32'(n), 32'(exp_n));
    check({nm, " valid_after"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    threshold = 16'sd100;
    filt_data = 16'sd500;
    res_ready = 1'b0;

    // Reset holds everything cleared even with enable and a crossing present.
    @(negedge clk);
    tick();
    check("rst filt_run", 32'(filt_run), 0);
    check("rst busy", 32'(busy), 0);
    check("rst res_valid", 32'(res_valid), 0);
    check("rst res_amp", 32'(res_amp), 0);
    check("rst ovf_cnt", 32'(ovf_cnt), 0);
    enable    = 1'b0;
    filt_data = 16'sd0;
    reset     = 1'b0;
    tick();
    check("idle no enable busy", 32'(busy), 0);

    // Settle timing, holdoff crossing ignored, single pulse peak 450.
    for (int i = 0; i < 8; i++) add(1, 16'd0, 0, 1, 1, 0, 16'd0);
    add(1, 16'd300, 0, 1, 1, 0, 16'd0);    // last SETTLE cycle: ignored
    add(1, 16'd120, 0, 1, 1, 0, 16'd0);    // first ARMED cycle: taken
    add(1, 16'd50,  0, 1, 1, 1, 16'd120);
    add(1, 16'd0,   1, 1, 1, 0, 16'd0);    // pop
    for (int i = 0; i < 14; i++) add(1, 16'd0, 0, 1, 1, 0, 16'd0);
    add(1, 16'd300, 0, 1, 1, 0, 16'd0);    // last HOLDOFF cycle: ignored
    add(1, 16'd0,   0, 1, 1, 0, 16'd0);
    add(1, 16'd50,  0, 1, 1, 0, 16'd0);
    add(1, 16'd120, 0, 1, 1, 0, 16'd0);
    add(1, 16'd300, 0, 1, 1, 0, 16'd0);
    add(1, 16'd450, 0, 1, 1, 0, 16'd0);
    add(1, 16'd450, 0, 1, 1, 0, 16'd0);
    add(1, 16'd400, 0, 1, 1, 1, 16'd450);
    add(1, 16'd0,   0, 1, 1, 1, 16'd450);  // held while not ready
    add(1, 16'd0,   1, 1, 1, 0, 16'd0);
    add(0, 16'd0,   0, 0, 0, 0, 16'd0);

    foreach (vecs[i]) begin
      enable    = vecs[i].en;
      filt_data = vecs[i].fd;
      res_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d filt_run", i), 32'(filt_run), 32'(vecs[i].e_run));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d res_amp", i), 32'(res_amp), 32'(vecs[i].e_amp));
    end
    res_ready = 1'b0;

    // Holdoff: second pulse 10 cycles later is ignored.
    start_run();
    pulse(16'd500, 0);
    repeat (8) tick();
    pulse(16'd600, 20);
    drain("holdoff10", 1, {16'd500, 16'd0, 16'd0, 16'd0});

    // Holdoff: 30 cycles apart gives two entries.
    pulse(16'd500, 28);
    pulse(16'd600, 20);
    drain("holdoff30", 2, {16'd500, 16'd600, 16'd0, 16'd0});

    // Overflow: six pulses into a four-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) pulse(16'(200 + 100 * i), 18);
    check("ovf count", 32'(ovf_cnt), 32'd2);
    check("ovf head", 32'(res_amp), 32'd200);
    drain("ovf drain", 4, {16'd200, 16'd300, 16'd400, 16'd500});

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 4; i++) pulse(16'(150 + 100 * i), 18);
    check("full head", 32'(res_amp), 32'd150);
    check("full ovf before", 32'(ovf_cnt), 32'd2);
    tick_fd(16'd850);
    res_ready = 1'b1;
    tick_fd(16'd0);
    res_ready = 1'b0;
    check("full+pop ovf", 32'(ovf_cnt), 32'd2);
    check("full+pop head", 32'(res_amp), 32'd250);
    repeat (18) tick();
    drain("full+pop drain", 4, {16'd250, 16'd350, 16'd450, 16'd850});

    // Reset during PEAK with two entries queued.
    pulse(16'd210, 18);
    pulse(16'd220, 18);
    check("pre-reset valid", 32'(res_valid), 32'd1);
    tick_fd(16'd990);
    filt_data = 16'sd0;
    #1 reset = 1'b1;
    #1;
    check("midrst filt_run", 32'(filt_run), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst res_valid", 32'(res_valid), 0);
    check("midrst res_amp", 32'(res_amp), 0);
    check("midrst ovf_cnt", 32'(ovf_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post-rst first edge busy", 32'(busy), 32'd1);
    check("post-rst filt_run", 32'(filt_run), 32'd1);
    repeat (20) tick();
    check("post-rst no push", 32'(res_valid), 32'd0);
    check("post-rst ovf", 32'(ovf_cnt), 32'd0);
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
